// File: rtl/in_to_fifo.sv
// Captures strobed input bytes into a small circular holding queue and writes
// them one at a time into a byte FIFO with an IDLE/WRITE/GAP handshake FSM.
module in_to_fifo #(
    parameter int WIDTH      = 8,
    parameter int HOLD_DEPTH = 2,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_strobe,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              fifo_busy,
    input  logic              fifo_full,
    output logic              fifo_we,
    output logic [WIDTH-1:0]  fifo_data,
    output logic              is_finish,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);
    // state | meaning
    // IDLE  | waiting for a queued byte and a ready FIFO
    // WRITE | fifo_we high this cycle, head popped at the end of it
    // GAP   | one quiet cycle so the FIFO can raise busy/full
    localparam int PTR_W = $clog2(HOLD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_queue [HOLD_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_count;
    logic             w_accept;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_start;

    assign w_accept = in_strobe && enable;
    assign w_full   = (r_count == CNT_W'(HOLD_DEPTH));
    assign w_pop    = (r_state == S_WRITE);
    // A full queue still accepts when the head leaves in the same cycle.
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_drop   = w_accept && w_full && !w_pop;
    assign w_start  = (r_state == S_IDLE) && enable && (r_count != '0)
                      && !fifo_busy && !fifo_full;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_GAP;
            S_GAP:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + CNT_W'(1);
            2'b01:   w_next_count = r_count - CNT_W'(1);
            default: w_next_count = r_count;
        endcase
    end

    // Storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (w_push) r_queue[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            fifo_we    <= 1'b0;
            fifo_data  <= '0;
            is_finish  <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next_count;
            is_finish <= (w_next_state == S_IDLE) && (w_next_count == '0);
            fifo_we   <= (w_next_state == S_WRITE);
            if (w_start) fifo_data <= r_queue[r_rd_ptr];
            if (w_push)  r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end
        end
    end
endmodule
